// File: rtl/tlc_phase_scheduler_if.sv
// Signal bundle between the junction phase scheduler and its environment:
// demand inputs from the sensor/time-of-day side, light codes to the lamp stage.
interface tlc_phase_scheduler_if;
  logic       peak;
  logic [2:0] sensor;
  logic [1:0] tl0;
  logic [1:0] tl1;
  logic [1:0] tl2;
  logic [1:0] phase;
  logic       phase_start;
  logic [2:0] req_pend;

  modport master (
    output peak, sensor,
    input  tl0, tl1, tl2, phase, phase_start, req_pend
  );

  modport slave (
    input  peak, sensor,
    output tl0, tl1, tl2, phase, phase_start, req_pend
  );
endinterface

// File: rtl/tlc_phase_scheduler.sv
// Three-approach phase scheduler: CLEAR -> GREEN -> YELLOW per approach, demand latching.
// Define TLC_SKIP_EN to skip approaches without pending requests (rest on approach 0).
module tlc_phase_scheduler #(
  parameter int unsigned GP0 = 32,
  parameter int unsigned GP1 = 32,
  parameter int unsigned GP2 = 16,
  parameter int unsigned GO0 = 16,
  parameter int unsigned GO1 = 16,
  parameter int unsigned GO2 = 8,
  parameter int unsigned YEL = 4,
  parameter int unsigned CLR = 4,
  parameter int unsigned TW  = 8
) (
  input logic                  clk,
  input logic                  reset,
  tlc_phase_scheduler_if.slave bus
);

  localparam logic [1:0] StClear  = 2'd0;
  localparam logic [1:0] StGreen  = 2'd1;
  localparam logic [1:0] StYellow = 2'd2;

  localparam logic [1:0] LtGreen  = 2'd0;
  localparam logic [1:0] LtYellow = 2'd1;
  localparam logic [1:0] LtRed    = 2'd2;

  logic [1:0]      state_q;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   glen_q;
  logic [1:0]      phase_q;
  logic            ps_q;
  logic [2:0]      pend_q;
  logic [2:0][1:0] tl_q;

  logic [TW-1:0] dur;
  logic          done;
  logic          enter_green;
  logic [1:0]    next_ap;
  logic [TW-1:0] next_glen;
  logic [2:0]    green_mask;
  logic [2:0]    pend_d;

  function automatic logic [1:0] rr_inc(logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    dur = TW'(CLR);
    case (state_q)
      StGreen:  dur = glen_q;
      StYellow: dur = TW'(YEL);
      default:  dur = TW'(CLR);
    endcase
  end

  assign done        = (timer_q == dur - TW'(1));
  assign enter_green = (state_q == StClear) && done;

`ifdef TLC_SKIP_EN
  logic [1:0] cand1;
  logic [1:0] cand2;
  assign cand1 = rr_inc(phase_q);
  assign cand2 = rr_inc(cand1);

  always_comb begin
    next_ap = 2'd0;
    if (pend_q[cand1])        next_ap = cand1;
    else if (pend_q[cand2])   next_ap = cand2;
    else if (pend_q[phase_q]) next_ap = phase_q;
  end
`else
  assign next_ap = rr_inc(phase_q);
`endif

  // Green length is fixed by peak as sampled on the CLEAR exit edge.
  always_comb begin
    next_glen = TW'(GO0);
    case (next_ap)
      2'd0:    next_glen = bus.peak ? TW'(GP0) : TW'(GO0);
      2'd1:    next_glen = bus.peak ? TW'(GP1) : TW'(GO1);
      2'd2:    next_glen = bus.peak ? TW'(GP2) : TW'(GO2);
      default: next_glen = TW'(GO0);
    endcase
  end

  // An approach ignores its own sensor while green; clearing on green entry wins over setting.
  assign green_mask = (state_q == StGreen) ? (3'b001 << phase_q) : 3'b000;

  always_comb begin
    pend_d = pend_q | (bus.sensor & ~green_mask);
    if (enter_green) pend_d[next_ap] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
      timer_q <= '0;
      glen_q  <= '0;
      phase_q <= 2'd2;
      ps_q    <= 1'b0;
      pend_q  <= 3'b000;
      tl_q    <= {LtRed, LtRed, LtRed};
    end else begin
      pend_q  <= pend_d;
      ps_q    <= 1'b0;
      timer_q <= done ? '0 : timer_q + TW'(1);
      if (done) begin
        case (state_q)
          StClear: begin
            state_q       <= StGreen;
            phase_q       <= next_ap;
            glen_q        <= next_glen;
            tl_q[next_ap] <= LtGreen;
            ps_q          <= 1'b1;
          end
          StGreen: begin
            state_q       <= StYellow;
            tl_q[phase_q] <= LtYellow;
          end
          default: begin
            state_q       <= StClear;
            tl_q[phase_q] <= LtRed;
          end
        endcase
      end
    end
  end

  assign bus.tl0         = tl_q[0];
  assign bus.tl1         = tl_q[1];
  assign bus.tl2         = tl_q[2];
  assign bus.phase       = phase_q;
  assign bus.phase_start = ps_q;
  assign bus.req_pend    = pend_q;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Self-checking bench for tlc_phase_scheduler: cycle reference model, fixed timelines, random demand.
`timescale 1ns/1ps
module tb_tlc_phase_scheduler;

  localparam int GP [3] = '{32, 32, 16};
  localparam int GO [3] = '{16, 16, 8};
  localparam int YEL = 4;
  localparam int CLR = 4;

  logic clk = 1'b0;
  logic reset;

  tlc_phase_scheduler_if bus ();

  tlc_phase_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference: segment kind (0 clear, 1 green, 2 yellow) and cycles left in it.
  int         m_seg, m_left, m_phase;
  logic [2:0] m_pend;
  logic [1:0] m_tl [3];
  logic       m_ps;

  task automatic model_reset();
    m_seg = 0; m_left = CLR; m_phase = 2; m_pend = 3'b000; m_ps = 1'b0;
    for (int i = 0; i < 3; i++) m_tl[i] = 2'd2;
  endtask

  function automatic int pick(logic [2:0] pend, int ph);
`ifdef TLC_SKIP_EN
    for (int k = 1; k <= 3; k++) if (pend[(ph + k) % 3]) return (ph + k) % 3;
    return 0;
`else
    return (ph + 1) % 3;
`endif
  endfunction

  task automatic model_step();
    logic [2:0] old;
    int nxt;
    if (reset) begin
      model_reset();
      return;
    end
    old = m_pend;
    for (int i = 0; i < 3; i++)
      if (bus.sensor[i] && !(m_seg == 1 && m_phase == i)) m_pend[i] = 1'b1;
    m_ps = 1'b0;
    m_left--;
    if (m_left == 0) begin
      if (m_seg == 0) begin
        nxt = pick(old, m_phase);
        m_phase = nxt; m_pend[nxt] = 1'b0; m_tl[nxt] = 2'd0; m_ps = 1'b1;
        m_left = bus.peak ? GP[nxt] : GO[nxt]; m_seg = 1;
      end else if (m_seg == 1) begin
        m_tl[m_phase] = 2'd1; m_left = YEL; m_seg = 2;
      end else begin
        m_tl[m_phase] = 2'd2; m_left = CLR; m_seg = 0;
      end
    end
  endtask

  function automatic logic [13:0] exp_vec();
    return {m_tl[0], m_tl[1], m_tl[2], 2'(m_phase), m_ps, m_pend};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {bus.tl0, bus.tl1, bus.tl2, bus.phase, bus.phase_start, bus.req_pend};
  endfunction

  function automatic int nonred();
    return int'(bus.tl0 != 2'd2) + int'(bus.tl1 != 2'd2) + int'(bus.tl2 != 2'd2);
  endfunction

  // Expected light of approach ap in cycle c with no sensors and a constant peak input.
  function automatic logic [1:0] tl_timeline(int c, int ap, bit pk);
    int g [3];
    int per, start, t;
    for (int i = 0; i < 3; i++) g[i] = pk ? GP[i] : GO[i];
    start = 0;
`ifdef TLC_SKIP_EN
    if (ap != 0) return 2'd2;
    per = g[0] + YEL + CLR;
`else
    per = g[0] + g[1] + g[2] + 3 * (YEL + CLR);
    for (int i = 0; i < ap; i++) start += g[i] + YEL + CLR;
`endif
    if (c < CLR) return 2'd2;
    t = ((c - CLR) % per) - start;
    if (t < 0) return 2'd2;
    if (t < g[ap]) return 2'd0;
    if (t < g[ap] + YEL) return 2'd1;
    return 2'd2;
  endfunction

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    advance();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    bus.peak = 1'b0; bus.sensor = 3'b000;
    do_reset();
    n_checks++;
    if (obs_vec() !== {2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state got %h want %h", obs_vec(), {2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 3'b000});
    end
  endtask

  task automatic test_timeline(bit pk, int ncyc);
    logic [1:0] got [3];
    bus.peak = pk; bus.sensor = 3'b000;
    do_reset();
    for (int n = 0; n < ncyc; n++) begin
      advance();
      got[0] = bus.tl0; got[1] = bus.tl1; got[2] = bus.tl2;
      for (int a = 0; a < 3; a++) begin
        n_checks++;
        if (got[a] !== tl_timeline(cyc, a, pk)) begin
          n_fail++;
          $display("FAIL timeline pk=%0d cyc=%0d tl%0d got %0d want %0d", pk, cyc, a, got[a],
                   tl_timeline(cyc, a, pk));
        end
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL timeline_model cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_peak_toggle();
    int glen0 = 0;
    bus.peak = 1'b1; bus.sensor = 3'b000;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      advance();
      if (cyc == 10) bus.peak = 1'b0;
      if (cyc <= 50 && bus.tl0 == 2'd0) glen0++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL peak_toggle_model cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (glen0 !== GP[0]) begin
      n_fail++;
      $display("FAIL peak_toggle_green_len got %0d want %0d", glen0, GP[0]);
    end
  endtask

  task automatic test_skip_pulse();
    bus.peak = 1'b0; bus.sensor = 3'b000;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      advance();
      bus.sensor = (cyc == 8) ? 3'b100 : 3'b000;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL skip_model cyc=%0d got %h want %h", cyc, obs_vec(), exp_vec());
      end
      if (cyc == 27) begin
        n_checks++;
        if (bus.req_pend !== 3'b100) begin
          n_fail++;
          $display("FAIL skip_pend_latched got %b want %b", bus.req_pend, 3'b100);
        end
      end
      if (cyc == 28) begin
        n_checks++;
`ifdef TLC_SKIP_EN
        if (bus.phase !== 2'd2 || bus.tl2 !== 2'd0 || bus.req_pend !== 3'b000) begin
          n_fail++;
          $display("FAIL skip_next got ph=%0d tl2=%0d pend=%b want ph=2 tl2=0 pend=000",
                   bus.phase, bus.tl2, bus.req_pend);
        end
`else
        if (bus.phase !== 2'd1 || bus.tl1 !== 2'd0) begin
          n_fail++;
          $display("FAIL skip_next got ph=%0d tl1=%0d want ph=1 tl1=0", bus.phase, bus.tl1);
        end
`endif
      end
    end
  endtask

  task automatic test_hold_sensor1();
    bus.peak = 1'b0; bus.sensor = 3'b010;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      advance();
      n_checks++;
      if (obs_vec() !== exp_vec() || nonred() > 1) begin
        n_fail++;
        $display("FAIL hold_s1 cyc=%0d got %h want %h nonred=%0d", cyc, obs_vec(), exp_vec(),
                 nonred());
      end
    end
  endtask

  task automatic test_reset_in_yellow();
    bit found = 1'b0;
    bus.peak = 1'b0; bus.sensor = 3'b010;
    do_reset();
    for (int n = 0; n < 200 && !found; n++) begin
      advance();
      if (bus.tl1 == 2'd1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_tl1_yellow got timeout want tl1=1 within 200 cycles");
    end
    reset = 1'b1;
    advance();
    n_checks++;
    if (obs_vec() !== {2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid got %h want %h", obs_vec(), {2'd2, 2'd2, 2'd2, 2'd2, 1'b0, 3'b000});
    end
    reset = 1'b0; bus.sensor = 3'b000; cyc = 0;
    for (int n = 0; n < 6; n++) begin
      advance();
      n_checks++;
      if (bus.tl0 !== ((cyc >= 4) ? 2'd0 : 2'd2) || bus.phase_start !== (cyc == 4)) begin
        n_fail++;
        $display("FAIL reset_recover cyc=%0d got tl0=%0d ps=%0d want tl0=%0d ps=%0d", cyc,
                 bus.tl0, bus.phase_start, (cyc >= 4) ? 0 : 2, cyc == 4);
      end
    end
  endtask

  task automatic test_random();
    bus.peak = 1'b0; bus.sensor = 3'b000;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      advance();
      n_checks++;
      if (obs_vec() !== exp_vec() || nonred() > 1) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %h want %h nonred=%0d", cyc, obs_vec(), exp_vec(),
                 nonred());
      end
      for (int i = 0; i < 3; i++) bus.sensor[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.peak = ~bus.peak;
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        advance();
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.peak = 1'b0;
    bus.sensor = 3'b000;
    model_reset();
    test_reset();
    test_timeline(1'b0, 140);
    test_timeline(1'b1, 220);
    test_peak_toggle();
    test_skip_pulse();
    test_hold_sensor1();
    test_reset_in_yellow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
